mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Round-robin arbiter that shares the single write/read port pair of the 1024×32 memory among NREQ requesters. It sits between the requester blocks and the memory's primary port (wenable/renable/write_address/read_address/data_in/data_out). Every access is gated by a per-request key that is compared against the memory's key_access output. Each request is a fixed three-cycle grant/access/response transaction with a registered round-robin pointer.

## Interface
- NREQ, 4: number of requesters (2..8).
- AW, 10: address width.
- DW, 32: data width.
- KW, 16: key width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  address; requester i uses slice [i*AW +: AW].
- req_wdata  in  NREQ*DW  write data; requester i uses slice [i*DW +: DW].
- req_key  in  NREQ*KW  access key; requester i uses slice [i*KW +: KW].
- req_ready  out  NREQ  one-hot acknowledge, registered.
- rsp_valid  out  NREQ  one-hot response strobe, registered.
- rsp_data  out  DW  read data, valid while rsp_valid is non-zero.
- rsp_err  out  1  key mismatch, valid while rsp_valid is non-zero.
- mem_wenable, mem_renable  out  1  memory strobes.
- mem_write_address, mem_read_address  out  AW  memory addresses; both carry the captured address.
- mem_data_in  out  DW  memory write data.
- mem_data_out  in  DW  memory read data, registered inside the memory.
- mem_key_access  in  KW  expected key.

## Operation
- Three states: IDLE, ACCESS, RESP.
- Registers: ptr (log2 NREQ bits), gnt (index), and the captured we, addr, wdata, and key_ok.
- IDLE:
  - If any req_valid is set, pick the winner: the first set bit searching ptr, ptr+1, … mod NREQ.
  - Capture the winner's we, addr, and wdata.
  - Capture key_ok = (req_key slice == mem_key_access).
  - Go to ACCESS. If no req_valid is set, stay in IDLE.
- ACCESS:
  - req_ready[gnt] = 1.
  - If key_ok: mem_wenable = we, mem_renable = !we.
  - If !key_ok: both strobes are 0.
  - Go to RESP.
- RESP:
  - rsp_valid[gnt] = 1 and rsp_err = !key_ok.
  - rsp_data = mem_data_out for a keyed read, else 0.
  - Set ptr = (gnt+1) mod NREQ and go to IDLE.
- The memory strobes are driven only in ACCESS. In every other state they are 0.
- The address and write-data outputs show the captured registers at all times.
- The command is sampled at the IDLE→ACCESS edge. A requester must hold valid and payload stable until it sees req_ready. It may drop or change them in the cycle after req_ready.
- A requester that lowers req_valid before it is granted loses its turn. No request state is stored per requester.
- The arbiter never issues an access on the memory's second (reg) port. That port stays available to other masters. A same-address collision on that port is outside this block.

## Timing
- Reset (async assert, sync release): state = IDLE, ptr = 0, gnt = 0.
- Reset values of outputs: req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, mem strobes = 0, mem addresses = 0, mem_data_in = 0.
- Latency:
  - Request seen in cycle t (IDLE).
  - req_ready and the memory strobe in cycle t+1.
  - Memory acts on the t+1 edge.
  - rsp_valid in t+2.
  - Next grant decision in t+3.
  - Peak throughput is 1 access per 3 cycles.
- Fairness: with all NREQ requesters continuously valid, each is served once every 3·NREQ cycles, in index order.
- Boundaries:
  - ptr wraps from NREQ-1 to 0.
  - A single requester that is always valid is re-granted every 3 cycles.
  - A read directly after a write to the same address returns the new data. The write commits at edge t+1 and the read is issued at t+4.
  - Reset asserted in ACCESS aborts the transaction and drops the strobes immediately (combinational from state). No rsp_valid is produced, and the memory write is not guaranteed.
- All outputs are decoded from registers only (state, gnt, captured fields). There is no combinational path from req_* to any output.

## Test plan
- Reset, then requester 0 writes 0xDEADBEEF to 0x005 with key 0x0032:
  - ready[0] in cycle 2.
  - mem_wenable = 1 with address 0x005.
  - rsp_valid[0] in cycle 3 with rsp_err = 0.
  - A following read of 0x005 returns rsp_data = 0xDEADBEEF.
- All four requesters valid from reset: grants go 0, 1, 2, 3, 0. Each rsp_valid is one-hot and they are spaced 3 cycles apart.
- Requester 2 reads 0x3FF with key 0x1234:
  - No memory strobe in ACCESS.
  - rsp_err = 1 and rsp_data = 0.
  - Memory contents are unchanged (checked by a later keyed read).
- Wrap: ptr = 3 after serving requester 2, with requesters 1 and 3 valid. Requester 3 wins; requester 1 wins the next round.
- Assert rst_n low during ACCESS of a read: strobes go to 0 at once, no rsp_valid appears, and state returns to IDLE with ptr = 0.
- Requester 1 drops valid in the cycle it would be picked: it gets no grant and no response, and the next valid requester is served instead.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port pair among NREQ requesters.
// Each transaction is key-gated and runs through IDLE, ACCESS and RESP.
module mem_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 10,
  parameter int DW   = 32,
  parameter int KW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ*KW-1:0] req_key,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_err,
  output logic              mem_wenable,
  output logic              mem_renable,
  output logic [AW-1:0]     mem_write_address,
  output logic [AW-1:0]     mem_read_address,
  output logic [DW-1:0]     mem_data_in,
  input  logic [DW-1:0]     mem_data_out,
  input  logic [KW-1:0]     mem_key_access
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            key_ok;

  logic            any;
  logic [PW-1:0]   win;
  int              idx;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        win = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      key_ok  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt     <= win;
            we_q    <= req_we[win];
            addr_q  <= req_addr[int'(win)*AW +: AW];
            wdata_q <= req_wdata[int'(win)*DW +: DW];
            key_ok  <= req_key[int'(win)*KW +: KW] == mem_key_access;
            state   <= ACCESS;
          end
        end
        ACCESS: state <= RESP;
        RESP: begin
          ptr   <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, never the live request inputs.
  assign req_ready = (state == ACCESS) ? (NREQ'(1) << gnt) : '0;
  assign rsp_valid = (state == RESP) ? (NREQ'(1) << gnt) : '0;
  assign rsp_err   = (state == RESP) && !key_ok;
  assign rsp_data  = (state == RESP && key_ok && !we_q) ? mem_data_out : '0;

  assign mem_wenable       = (state == ACCESS) && key_ok && we_q;
  assign mem_renable       = (state == ACCESS) && key_ok && !we_q;
  assign mem_write_address = addr_q;
  assign mem_read_address  = addr_q;
  assign mem_data_in       = wdata_q;

endmodule
